// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// master drives requests and accepts results; slave is the unit itself.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op1, op2, funct3, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op1, op2, funct3, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide: fixed WIDTH+1 cycle latency per op,
// sign handled by magnitude pre-conversion and post-negation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] op1_q, op2_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] m_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] lo_q;     // product low half / dividend shifting into quotient
  logic [WIDTH:0]   acc_q;    // product high half / partial remainder
  logic             neg_lo_q, neg_rem_q;
  logic [CW-1:0]    cnt_q;

  logic             in_ready, out_valid, busy;
  logic             is_div, a_sgn, b_sgn, op2_zero, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_div    = f3_q[2];
  assign a_sgn     = op1_q[WIDTH-1] & ((f3_q == 3'b001) | (f3_q == 3'b010) | (f3_q[2] & ~f3_q[0]));
  assign b_sgn     = op2_q[WIDTH-1] & ((f3_q == 3'b001) | (f3_q[2] & ~f3_q[0]));
  assign a_mag     = a_sgn ? -op1_q : op1_q;
  assign b_mag     = b_sgn ? -op2_q : op2_q;
  assign op2_zero  = (op2_q == '0);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) state_d = PREP;
      end
      PREP: state_d = CALC;
      CALC: if (last_iter) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration step for each op family
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic           div_ok;
  assign mul_sum  = acc_q + (lo_q[0] ? {1'b0, m_q} : '0);
  assign div_sh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_ok   = (div_sh >= {1'b0, m_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      f3_q      <= '0;
      m_q       <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op1_q <= bus.op1;
          op2_q <= bus.op2;
          f3_q  <= bus.funct3;
        end
        PREP: begin
          m_q       <= is_div ? b_mag : a_mag;
          lo_q      <= is_div ? a_mag : b_mag;
          acc_q     <= '0;
          cnt_q     <= '0;
          // Divide by zero keeps the all-ones quotient unsigned-looking
          neg_lo_q  <= (a_sgn ^ b_sgn) & ~(is_div & op2_zero);
          neg_rem_q <= a_sgn;
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div) begin
            acc_q <= div_ok ? div_diff : div_sh;
            lo_q  <= {lo_q[WIDTH-2:0], div_ok};
          end else begin
            acc_q <= {1'b0, mul_sum[WIDTH:1]};
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, res;
  assign prod   = {acc_q[WIDTH-1:0], lo_q};
  assign prod_s = neg_lo_q ? -prod : prod;
  assign quo_s  = neg_lo_q ? -lo_q : lo_q;
  assign rem_s  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    res = '0;
    if (is_div)                res = f3_q[1] ? rem_s : quo_s;
    else if (f3_q[1:0] == 2'b00) res = prod_s[WIDTH-1:0];
    else                       res = prod_s[2*WIDTH-1:WIDTH];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.result    = (state_q == DONE) ? res : '0;
endmodule
